// File: rtl/pwm_pkg.sv
// Shared PWM types and timebase helpers.
// Optional PWM_POLARITY_EN adds per-channel output polarity.
package pwm_pkg;

   typedef enum logic [1:0] {
      FRONT  = 2'b00,
      BACK   = 2'b01,
      CENTER = 2'b10
   } pwm_mode_t;

   // Clocks per duty step.
   function automatic int pwm_tps(
      input int clk_ns,
      input int per_ns,
      input int size
   );
      return per_ns / (clk_ns * (1 << size));
   endfunction

   function automatic bit pwm_tps_ok(
      input int clk_ns,
      input int per_ns,
      input int size
   );
      int unit;
      unit = clk_ns * (1 << size);
      return (unit > 0) && (per_ns >= unit) &&
             (per_ns % unit == 0);
   endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler and step counter for the PWM period.
// Emits the boundary flag and a registered period-start pulse.
module pwm_timebase #(
   parameter int TPS  = 125,
   parameter int SIZE = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   output logic [SIZE-1:0] step,
   output logic            bound,
   output logic            synch
);

   localparam int PW = (TPS > 1) ? $clog2(TPS) : 1;
   localparam logic [PW-1:0]   PMAX = PW'(TPS - 1);
   localparam logic [SIZE-1:0] SMAX = '1;

   logic [PW-1:0] pre;
   logic          pwrap;

   assign pwrap = (pre == PMAX);
   assign bound = en && pwrap && (step == SMAX);

   always_ff @(posedge clk) begin
      if (!rst_n || !en) begin
         pre   <= '0;
         step  <= '0;
         synch <= 1'b0;
      end else begin
         synch <= (pre == '0) && (step == '0);
         pre   <= pwrap ? '0 : pre + 1'b1;
         if (pwrap)
            step <= step + 1'b1;
      end
   end

endmodule

// File: rtl/multi_pwm_generator.sv
// Multi-channel PWM with shadowed duty/mode per period.
// Define PWM_POLARITY_EN to add the Polarity input.
module multi_pwm_generator
   import pwm_pkg::*;
#(
   parameter int CLOCK_PERIOD_NS = 20,
   parameter int PWM_PERIOD_NS   = 20_000,
   parameter int SIZE            = 3,
   parameter int CHANNELS        = 4
) (
   input  logic                     Clock,
   input  logic                     Reset_n,
   input  logic                     Enable,
   input  logic                     Load,
   input  logic [CHANNELS*SIZE-1:0] Data,
   input  logic [1:0]               Mode,
`ifdef PWM_POLARITY_EN
   input  logic [CHANNELS-1:0]      Polarity,
`endif
   output logic [CHANNELS-1:0]      PWM,
   output logic                     Synch
);

   localparam int TPS =
      pwm_tps(CLOCK_PERIOD_NS, PWM_PERIOD_NS, SIZE);
   localparam logic [SIZE:0] FULL = (SIZE+1)'(1 << SIZE);

   if (!pwm_tps_ok(CLOCK_PERIOD_NS, PWM_PERIOD_NS, SIZE))
   begin : g_chk
      $fatal(1, "PWM period not a whole number of steps");
   end

   logic [CHANNELS*SIZE-1:0] pend_d, act_d, nxt_d;
   logic [1:0]               pend_m, act_m, nxt_m;
   logic [CHANNELS-1:0]      act_p, hits;
   logic [SIZE-1:0]          step;
   logic                     bound;

   assign nxt_d = Load ? Data : pend_d;
   assign nxt_m = Load ? Mode : pend_m;

   // Active copy tracks pending while idle, else only at the boundary.
   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         pend_d <= '0;
         act_d  <= '0;
         pend_m <= FRONT;
         act_m  <= FRONT;
      end else begin
         pend_d <= nxt_d;
         pend_m <= nxt_m;
         if (!Enable || bound) begin
            act_d <= nxt_d;
            act_m <= nxt_m;
         end
      end
   end

`ifdef PWM_POLARITY_EN
   logic [CHANNELS-1:0] pend_p, nxt_p;

   assign nxt_p = Load ? Polarity : pend_p;

   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         pend_p <= '0;
         act_p  <= '0;
      end else begin
         pend_p <= nxt_p;
         if (!Enable || bound)
            act_p <= nxt_p;
      end
   end
`else
   assign act_p = '0;
`endif

   pwm_timebase #(
      .TPS  (TPS),
      .SIZE (SIZE)
   ) u_timebase (
      .clk   (Clock),
      .rst_n (Reset_n),
      .en    (Enable),
      .step  (step),
      .bound (bound),
      .synch (Synch)
   );

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      logic [SIZE:0] d, s, off;
      logic          hit;

      assign d   = {1'b0, act_d[k*SIZE +: SIZE]};
      assign s   = {1'b0, step};
      assign off = (FULL - d) >> 1;

      always_comb begin
         hit = 1'b0;
         unique case (1'b1)
            (act_m == BACK):
               hit = (s >= FULL - d);
            (act_m == CENTER):
               hit = (s >= off) && (s < off + d);
            default:
               hit = (s < d);
         endcase
      end

      assign hits[k] = hit;
   end

   always_ff @(posedge Clock) begin
      if (!Reset_n || !Enable)
         PWM <= '0;
      else
         PWM <= hits ^ act_p;
   end

endmodule

// File: tb/tb_multi_pwm_generator.sv
// Bench for multi_pwm_generator: vector table, corner sequences
// and randomized traffic against a period-position model.
module tb_multi_pwm_generator;

   localparam int TPS   = 125;
   localparam int STEPS = 8;
   localparam int PER   = TPS * STEPS;
   localparam int NV    = 6;
   localparam logic [10:0] NO = 11'd2047;
`ifdef PWM_POLARITY_EN
   localparam bit POL_EN = 1'b1;
`else
   localparam bit POL_EN = 1'b0;
`endif

   typedef struct packed {
      logic [1:0]       mode;
      logic [11:0]      data;
      logic [3:0][10:0] cnt;
      logic [3:0][10:0] first;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n, en, load;
   logic [11:0] data;
   logic [1:0]  mode;
   logic [3:0]  pol;
   logic [3:0]  pwm;
   logic        synch;

   int cmp = 0;
   int bad = 0;

   int          m_n;
   logic [11:0] m_pd, m_ad;
   logic [1:0]  m_pm, m_am;
   logic [3:0]  m_pp, m_ap;

   vec_t vec [NV];

   always #10 clk = ~clk;

   multi_pwm_generator #(
      .CLOCK_PERIOD_NS (20),
      .PWM_PERIOD_NS   (20_000),
      .SIZE            (3),
      .CHANNELS        (4)
   ) dut (
      .Clock    (clk),
      .Reset_n  (rst_n),
      .Enable   (en),
      .Load     (load),
      .Data     (data),
      .Mode     (mode),
`ifdef PWM_POLARITY_EN
      .Polarity (pol),
`endif
      .PWM      (pwm),
      .Synch    (synch)
   );

   // Expected level at position n of a period.
   function automatic logic ref_hit(
      input logic [1:0] md,
      input int d,
      input int n
   );
      int st, o;
      st = n / TPS;
      o  = (STEPS - d) / 2;
      case (md)
         2'd1:    return st >= STEPS - d;
         2'd2:    return (st >= o) && (st < o + d);
         default: return st < d;
      endcase
   endfunction

   task automatic check(input string nm, input int act,
                        input int req);
      cmp++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d",
                  nm, act, req);
      end
   endtask

   task automatic tick();
      logic [3:0]  ep;
      logic        es;
      logic [11:0] nd;
      logic [1:0]  nm;
      logic [3:0]  np;
      @(posedge clk);
      ep = '0;
      es = 1'b0;
      if (!rst_n) begin
         m_n = 0;
         m_pd = '0; m_ad = '0;
         m_pm = '0; m_am = '0;
         m_pp = '0; m_ap = '0;
      end else begin
         if (en) begin
            for (int k = 0; k < 4; k++)
               ep[k] = ref_hit(m_am, int'(m_ad[k*3 +: 3]), m_n)
                       ^ (POL_EN & m_ap[k]);
            es = (m_n == 0);
         end
         nd = load ? data : m_pd;
         nm = load ? mode : m_pm;
         np = load ? pol  : m_pp;
         if (!en || m_n == PER - 1) begin
            m_ad = nd; m_am = nm; m_ap = np;
         end
         m_pd = nd; m_pm = nm; m_pp = np;
         m_n = en ? (m_n + 1) % PER : 0;
      end
      #1;
      cmp++;
      if ({pwm, synch} !== {ep, es}) begin
         bad++;
         $display("FAIL model_cycle @%0t: pwm=%b synch=%b, required pwm=%b synch=%b",
                  $time, pwm, synch, ep, es);
      end
   endtask

   // Ticks until Synch is seen; returns ticks taken.
   task automatic wait_synch(output int gap);
      gap = 0;
      do begin
         tick();
         gap++;
      end while (!synch && gap < 2 * PER + 100);
      if (!synch)
         check("synch_timeout", 0, 1);
   endtask

   // Window starts on the current (Synch) cycle.
   task automatic measure(output int c [4], output int f [4],
                          output int sy);
      sy = 0;
      for (int k = 0; k < 4; k++) begin
         c[k] = 0;
         f[k] = -1;
      end
      for (int i = 0; i < PER; i++) begin
         if (i > 0)
            tick();
         sy += int'(synch);
         for (int k = 0; k < 4; k++)
            if (pwm[k]) begin
               c[k]++;
               if (f[k] < 0)
                  f[k] = i;
            end
      end
   endtask

   initial begin
      int c [4];
      int f [4];
      int sy, gap, offc, hi;

      vec[0] = '{2'd0, {3'd7, 3'd3, 3'd2, 3'd6},
                 {11'd875, 11'd375, 11'd250, 11'd750},
                 {11'd0, 11'd0, 11'd0, 11'd0}};
      vec[1] = '{2'd1, {3'd7, 3'd3, 3'd2, 3'd6},
                 {11'd875, 11'd375, 11'd250, 11'd750},
                 {11'd125, 11'd625, 11'd750, 11'd250}};
      vec[2] = '{2'd2, {3'd7, 3'd3, 3'd2, 3'd6},
                 {11'd875, 11'd375, 11'd250, 11'd750},
                 {11'd0, 11'd250, 11'd375, 11'd125}};
      vec[3] = '{2'd3, {3'd5, 3'd4, 3'd0, 3'd1},
                 {11'd625, 11'd500, 11'd0, 11'd125},
                 {11'd0, 11'd0, NO, 11'd0}};
      vec[4] = '{2'd2, {3'd5, 3'd4, 3'd0, 3'd1},
                 {11'd625, 11'd500, 11'd0, 11'd125},
                 {11'd125, 11'd250, NO, 11'd375}};
      vec[5] = '{2'd1, 12'd0,
                 {11'd0, 11'd0, 11'd0, 11'd0},
                 {NO, NO, NO, NO}};

      rst_n = 1'b0;
      en    = 1'b1;
      load  = 1'b1;
      data  = 12'hfff;
      mode  = 2'd1;
      pol   = 4'd0;
      m_n = 0;
      m_pd = '0; m_ad = '0;
      m_pm = '0; m_am = '0;
      m_pp = '0; m_ap = '0;

      for (int i = 0; i < 3; i++) begin
         tick();
         check("reset_pwm", int'(pwm), 0);
         check("reset_synch", int'(synch), 0);
      end
      rst_n = 1'b1;
      load  = 1'b0;
      en    = 1'b0;
      for (int i = 0; i < 5; i++)
         tick();
      check("idle_pwm", int'(pwm), 0);
      en = 1'b1;
      tick();
      check("synch_on_enable", int'(synch), 1);

      for (int i = 0; i < NV; i++) begin
         data = vec[i].data;
         mode = vec[i].mode;
         load = 1'b1;
         tick();
         load = 1'b0;
         wait_synch(gap);
         measure(c, f, sy);
         check($sformatf("v%0d_synch_cnt", i), sy, 1);
         for (int k = 0; k < 4; k++) begin
            check($sformatf("v%0d_ch%0d_high", i, k),
                  c[k], int'(vec[i].cnt[k]));
            check($sformatf("v%0d_ch%0d_first", i, k), f[k],
                  vec[i].first[k] == NO ? -1
                                        : int'(vec[i].first[k]));
         end
      end

      // Load mid-period takes effect only at the next period.
      data = 12'd6;
      mode = 2'd0;
      load = 1'b1;
      tick();
      load = 1'b0;
      wait_synch(gap);
      hi = 0;
      for (int i = 0; i < PER; i++) begin
         if (i == 300) begin
            data = 12'd2;
            load = 1'b1;
         end
         if (i > 0)
            tick();
         load = 1'b0;
         hi += int'(pwm[0]);
      end
      check("midload_old_high", hi, 750);
      wait_synch(gap);
      check("synch_period", gap, 1);
      measure(c, f, sy);
      check("midload_new_high", c[0], 250);

      // Reset mid-period aborts; Load during reset ignored.
      wait_synch(gap);
      for (int i = 0; i < 399; i++)
         tick();
      rst_n = 1'b0;
      load  = 1'b1;
      data  = 12'hfff;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("midreset_out", int'({pwm, synch}), 0);
      end
      rst_n = 1'b1;
      load  = 1'b0;
      tick();
      check("synch_after_reset", int'(synch), 1);
      measure(c, f, sy);
      check("after_reset_ch0", c[0], 0);
      check("after_reset_ch3", c[3], 0);
      wait_synch(gap);
      check("after_reset_period", gap, 1);

`ifdef PWM_POLARITY_EN
      data = 12'd6;
      mode = 2'd0;
      pol  = 4'b0001;
      load = 1'b1;
      tick();
      load = 1'b0;
      wait_synch(gap);
      measure(c, f, sy);
      check("pol_ch0_high", c[0], 250);
      en = 1'b0;
      tick();
      check("pol_disabled", int'(pwm), 0);
      en = 1'b1;
`endif

      offc = 0;
      for (int n = 0; n < 9000; n++) begin
         if ($urandom_range(199) == 0) begin
            data = 12'($urandom);
            mode = 2'($urandom);
            if (POL_EN)
               pol = 4'($urandom);
            load = 1'b1;
         end
         if (offc > 0) begin
            offc--;
            if (offc == 0)
               en = 1'b1;
         end else if ($urandom_range(1999) == 0) begin
            en   = 1'b0;
            offc = int'($urandom_range(20, 1));
         end
         rst_n = ($urandom_range(4999) != 0);
         tick();
         load  = 1'b0;
         rst_n = 1'b1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               cmp, bad);
      $finish;
   end

endmodule
